// File: rtl/sync_filter_bus.sv
// Multi-channel async input conditioner: per-channel synchronizer chain, glitch
// filter with programmable threshold, edge pulses, sticky change flags and a rejection counter.
module sync_filter_bus #(
    parameter int unsigned      NCH   = 4,
    parameter int unsigned      NSYNC = 2,
    parameter int unsigned      NFILT = 4,
    parameter logic [NCH-1:0]   INIT  = '0
) (
    input  logic             out_clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   in,
    input  logic [NFILT-1:0] filt_len,
    input  logic             clr_sticky,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [NCH-1:0]   changed,
    output logic [15:0]      glitch_cnt
);

    (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0][NCH-1:0] sync_q;
    logic [NSYNC-1:0][NCH-1:0] sync_d;
    (* ASYNC_REG = "TRUE" *) logic [NCH-1:0] s;

    logic [NCH-1:0]            out_q, out_d;
    logic [NCH-1:0][NFILT-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            rise_q, rise_d;
    logic [NCH-1:0]            fall_q, fall_d;
    logic [NCH-1:0]            changed_q, changed_d;
    logic [15:0]               glitch_q, glitch_d;
    logic [NCH-1:0]            reject;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in;
        for (int unsigned i = 1; i < NSYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s = sync_q[NSYNC-1];
    end

    // >= (not ==) lets a lowered threshold commit a long-running count at once
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        reject = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (s[ch] == out_q[ch]) begin
                cnt_d[ch]  = '0;
                reject[ch] = (cnt_q[ch] != '0);
            end else if (cnt_q[ch] >= filt_len) begin
                out_d[ch] = s[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    always_comb begin
        rise_d    = out_d & ~out_q;
        fall_d    = ~out_d & out_q;
        changed_d = (clr_sticky ? '0 : changed_q) | rise_d | fall_d;
        glitch_d  = glitch_q;
        if (clr_sticky) begin
            glitch_d = {15'd0, |reject};
        end else if ((|reject) && (glitch_q != '1)) begin
            glitch_d = glitch_q + 16'd1;
        end
    end

    always_ff @(posedge out_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {NSYNC{INIT}};
            out_q     <= INIT;
            cnt_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= '0;
            glitch_q  <= '0;
        end else begin
            sync_q    <= sync_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            glitch_q  <= glitch_d;
        end
    end

    assign out        = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign changed    = changed_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sync_filter_bus.sv
// Self-checking bench for sync_filter_bus: directed scenarios plus random traffic
// compared every cycle against a streak-based behavioural model.
module tb_sync_filter_bus;

    localparam int NCH   = 4;
    localparam int NSYNC = 2;
    localparam int NFILT = 4;

    logic             out_clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   din;
    logic [NFILT-1:0] filt;
    logic             clr;
    logic [NCH-1:0]   out_w, rise_w, fall_w, chg_w;
    logic [15:0]      glitch_w;

    int tests = 0;
    int fails = 0;
    bit chk_en;

    sync_filter_bus #(
        .NCH   (NCH),
        .NSYNC (NSYNC),
        .NFILT (NFILT),
        .INIT  ('0)
    ) dut (
        .out_clk    (out_clk),
        .rst_n      (rst_n),
        .in         (din),
        .filt_len   (filt),
        .clr_sticky (clr),
        .out        (out_w),
        .rise       (rise_w),
        .fall       (fall_w),
        .changed    (chg_w),
        .glitch_cnt (glitch_w)
    );

    always #5 out_clk = ~out_clk;

    // Model: a change commits once the synchronized input has disagreed with
    // the filtered level for more than filt_len consecutive samples.
    logic [NCH-1:0] m_pipe [$];
    int             m_streak [NCH];
    logic [NCH-1:0] m_out, m_rise, m_fall, m_chg;
    int             m_gcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < NSYNC; i++) m_pipe.push_back('0);
        for (int i = 0; i < NCH; i++) m_streak[i] = 0;
        m_out = '0; m_rise = '0; m_fall = '0; m_chg = '0; m_gcnt = 0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] s;
        bit rej;
        int lim;
        s = m_pipe.pop_front();
        m_pipe.push_back(din);
        rej = 0; m_rise = '0; m_fall = '0;
        lim = int'(filt);
        for (int c = 0; c < NCH; c++) begin
            if (s[c] == m_out[c]) begin
                if (m_streak[c] > 0) rej = 1;
                m_streak[c] = 0;
            end else begin
                m_streak[c]++;
                if (m_streak[c] > lim) begin
                    m_out[c] = s[c];
                    if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                    m_streak[c] = 0;
                end
            end
        end
        if (clr) m_chg = '0;
        m_chg = m_chg | m_rise | m_fall;
        if (clr) m_gcnt = rej ? 1 : 0;
        else if (rej) m_gcnt = (m_gcnt >= 65535) ? 65535 : m_gcnt + 1;
    endtask

    task automatic tick();
        if (!rst_n) model_reset(); else model_edge();
        @(posedge out_clk);
        #1;
        if (chk_en) begin
            chk("out", out_w, m_out);
            chk("rise", rise_w, m_rise);
            chk("fall", fall_w, m_fall);
            chk("changed", chg_w, m_chg);
            chk("glitch", glitch_w, m_gcnt);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, out_w, '0);
        chk({tag, "_rise"}, rise_w, '0);
        chk({tag, "_fall"}, fall_w, '0);
        chk({tag, "_chg"}, chg_w, '0);
        chk({tag, "_glitch"}, glitch_w, '0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [NCH-1:0] exp_v;

        din = '0; filt = 4'd3; clr = 1'b0; rst_n = 1'b0; chk_en = 1'b1;
        model_reset();
        #2;
        chk_all_zero("rst");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();

        // single step on ch0, filt_len=3: 6-edge latency
        din[0] = 1'b1;
        n = 0;
        while (!out_w[0] && n < 20) begin tick(); n++; end
        chk("lat_ch0", n, 6);
        chk("rise_ch0", rise_w[0], 1'b1);
        chk("chg_ch0", chg_w[0], 1'b1);
        tick();
        chk("rise_ch0_once", rise_w[0], 1'b0);

        // 3-cycle low pulse on ch1 is rejected
        din[1] = 1'b1;
        repeat (8) tick();
        din[1] = 1'b0;
        repeat (3) tick();
        din[1] = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin tick(); seen |= fall_w[1]; end
        chk("glitch_out1", out_w[1], 1'b1);
        chk("glitch_nofall", seen, 1'b0);
        chk("glitch_cnt1", glitch_w, 16'd1);

        // filt_len=0, ch3 toggles every 4 clocks: 3-edge latency
        filt = 4'd0;
        for (int k = 1; k <= 24; k++) begin
            din[3] = (((k - 1) / 4) % 2) != 0;
            tick();
            chk("lat0_ch3", out_w[3], (k >= 3) ? (((k - 3) / 4) % 2) : 0);
            chk("rf_excl", rise_w & fall_w, '0);
        end
        chk("glitch_keep", glitch_w, 16'd1);

        // sticky set wins over coincident clear on ch2
        din[2] = 1'b1;
        repeat (4) tick();
        chk("ch2_high", out_w[2], 1'b1);
        din[2] = 1'b0;
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ch2_fall", fall_w[2], 1'b1);
        chk("ch2_set_wins", chg_w[2], 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_changed", chg_w, '0);
        chk("clr_glitch", glitch_w, 16'd0);

        // random traffic, threshold changed on the fly (including lowering)
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) filt = 4'($urandom_range(0, 5));
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) == 0) din[c] = ~din[c];
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr = 1'b0;

        // saturation: ch0/ch1 toggled anti-phase give a rejection every cycle
        filt = 4'd1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_en = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            din[0] = ~din[0];
            din[1] = din[0] ^ m_out[0] ^ m_out[1] ^ 1'b1;
            tick();
        end
        chk_en = 1'b1;
        chk("sat_ffff", glitch_w, 16'hFFFF);
        chk("sat_model", glitch_w, m_gcnt);
        din[0] = ~din[0];
        din[1] = din[0] ^ m_out[0] ^ m_out[1] ^ 1'b1;
        tick();
        chk("sat_hold", glitch_w, 16'hFFFF);

        // reset aborts a pending change; all channels then rise together
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        din = '0; filt = 4'd3;
        repeat (4) tick();
        din[0] = 1'b1;
        repeat (4) tick();
        din = '1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst_mid");
        tick(); tick();
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        n = 0;
        seen = 0;
        while (out_w == '0 && n < 20) begin
            tick(); n++;
            if (out_w == '0) seen |= (rise_w != '0);
        end
        exp_v = '1;
        chk("rel_lat", n, NSYNC + 3 + 1);
        chk("rel_out", out_w, exp_v);
        chk("rel_rise", rise_w, exp_v);
        chk("rel_early_rise", seen, 1'b0);
        tick();
        chk("rel_rise_once", rise_w, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_filter_bus.md
SYNC_FILTER_BUS -- requirements
Module: sync_filter_bus

Interface
REQ-001 Parameter NCH, default 4: number of independent input channels, legal 1..32.
REQ-002 Parameter NSYNC, default 2: synchronizer flip-flop stages per channel, legal 2..4.
REQ-003 Parameter NFILT, default 4: width of the per-channel filter counter and of filt_len.
REQ-004 Parameter INIT, default {NCH{1'b0}}: reset value of the sync stages and of the filtered state.
REQ-005 out_clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low; one clock, and reset is asynchronous and active-low.
REQ-007 in  input  NCH  asynchronous level inputs, one bit per channel.
REQ-008 filt_len  input  NFILT  glitch-filter threshold in out_clk cycles, quasi-static, common to all channels.
REQ-009 clr_sticky  input  1  single-cycle pulse; clears changed and glitch_cnt.
REQ-010 out  output  NCH  filtered, synchronized level per channel.
REQ-011 rise  output  NCH  one-cycle pulse when out[i] goes 0->1.
REQ-012 fall  output  NCH  one-cycle pulse when out[i] goes 1->0.
REQ-013 changed  output  NCH  sticky flag per channel, set by any rise or fall.
REQ-014 glitch_cnt  output  16  saturating count of cycles in which at least one pending change was rejected.

Function
REQ-015 Each in[i] SHALL pass through an NSYNC-deep flop chain; chain output s[i] SHALL be marked ASYNC_REG.
REQ-016 Each channel SHALL hold a filtered state out[i] and an NFILT-bit counter cnt[i].
REQ-017 If s[i] == out[i], then cnt[i] SHALL become 0 on the next edge.
REQ-018 If s[i] != out[i] and cnt[i] >= filt_len, then out[i] SHALL take s[i] and cnt[i] SHALL become 0 on the next edge.
REQ-019 If s[i] != out[i] and cnt[i] < filt_len, then cnt[i] SHALL increment by 1 on the next edge.
REQ-020 Latency SHALL be exact: a stable change on in[i] reaches out[i] NSYNC + filt_len + 1 edges later (filt_len=0 gives NSYNC+1).
REQ-021 A change whose s[i] duration is at most filt_len cycles SHALL NOT reach out[i].
REQ-022 If filt_len is lowered below a running cnt[i], the >= comparison SHALL commit the change on the next edge; cnt[i] SHALL never wrap.
REQ-023 rise[i]/fall[i] SHALL be registered and asserted for exactly the one cycle following the out[i] update; they SHALL never both be asserted.
REQ-024 changed[i] SHALL set on the edge that out[i] changes; clr_sticky SHALL clear it; when set and clear coincide, set wins.
REQ-025 A rejection occurs when cnt[i] != 0 and s[i] == out[i].
REQ-026 glitch_cnt SHALL increment by 1 in any cycle with at least one rejection in any channel, and SHALL saturate at 16'hFFFF.
REQ-027 clr_sticky SHALL zero glitch_cnt; when clear and increment coincide, the result SHALL be 1.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled per REQ-017..024.

Reset
REQ-029 While rst_n=0, the following SHALL hold: sync stages=INIT, out=INIT, cnt=0, rise=0, fall=0, changed=0, glitch_cnt=0.
REQ-030 Reset asserted mid-filter SHALL abort the pending change; no rise or fall pulse SHALL be emitted for it.
REQ-031 After release, an in[i] that differs from INIT SHALL be processed as a normal change per REQ-020, and SHALL produce its edge pulse.

Verification
REQ-032 NSYNC=2, filt_len=3, in[0] steps 0->1 and holds: out[0]=1 exactly 6 edges after the change; rise[0]=1 for one cycle; changed[0]=1.
REQ-033 filt_len=3, in[1] 1->0 pulse lasting 3 clocks: out[1] stays 1; no fall; glitch_cnt=1.
REQ-034 filt_len=0, in toggles every 4 clocks: out follows with 3-edge latency; rise and fall alternate; glitch_cnt stays 0.
REQ-035 Set changed[2] and assert clr_sticky in the same cycle as a new fall[2]: changed[2] remains 1. Then clr_sticky alone: changed=0 and glitch_cnt=0.
REQ-036 Force 70000 rejections: glitch_cnt holds 16'hFFFF.
REQ-037 Assert rst_n=0 with cnt[0]=2 pending, INIT=0, in=all ones; release: all outputs 0 during reset; all out bits rise together NSYNC+filt_len+1 edges after release, with one rise pulse each.
